// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axil_pkg
// Description : Shared constants for the AXI4-Lite access scheduler:
//               response codes, FSM state encoding and grant encoding.
// Revision    : 1.0
// ============================================================================
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WR_ACCESS = 3'd1;
  localparam logic [2:0] ST_B_RESP    = 3'd2;
  localparam logic [2:0] ST_RD_ACCESS = 3'd3;
  localparam logic [2:0] ST_R_RESP    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_WR_ACCESS = ST_WR_ACCESS,
    S_B_RESP    = ST_B_RESP,
    S_RD_ACCESS = ST_RD_ACCESS,
    S_R_RESP    = ST_R_RESP
  } state_e;

  localparam logic GRANT_READ  = 1'b0;
  localparam logic GRANT_WRITE = 1'b1;

  function automatic logic [1:0] resp_of(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axil_access_grant.sv
`default_nettype none
// ============================================================================
// Module      : axil_access_grant
// Description : Read/write grant decision for the access scheduler.
//               AXIL_ACCESS_SCHED_RR_EN selects round-robin with a last-grant
//               flop; otherwise writes have fixed priority.
// Revision    : 1.0
// ============================================================================
module axil_access_grant
  import axil_pkg::*;
(
`ifdef AXIL_ACCESS_SCHED_RR_EN
  input  logic i_clock,
  input  logic i_areset_n,
  input  logic i_accept,
`endif
  input  logic i_wr_req,
  input  logic i_rd_req,
  output logic o_valid,
  output logic o_grant
);

  assign o_valid = i_wr_req | i_rd_req;

`ifdef AXIL_ACCESS_SCHED_RR_EN
  logic last_q;
  logic last_d;

  always_comb begin
    o_grant = GRANT_READ;
    last_d  = last_q;
    // On a conflict, hand the slot to whichever type did not win last time.
    if (i_wr_req && i_rd_req) begin
      o_grant = (last_q == GRANT_WRITE) ? GRANT_READ : GRANT_WRITE;
    end else if (i_wr_req) begin
      o_grant = GRANT_WRITE;
    end
    if (i_accept) begin
      last_d = o_grant;
    end
  end

  always_ff @(posedge i_clock or negedge i_areset_n) begin
    if (!i_areset_n) begin
      last_q <= GRANT_READ;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    o_grant = i_wr_req ? GRANT_WRITE : GRANT_READ;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/axil_access_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : axil_access_scheduler
// Description : Serialises AXI4-Lite reads and writes onto a single-ported
//               register file, one transaction in flight at a time.
//               Optional: AXIL_ACCESS_SCHED_RR_EN enables round-robin grant.
// Revision    : 1.0
// ============================================================================
module axil_access_scheduler
  import axil_pkg::*;
#(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 32
) (
  input  logic                  i_clock,
  input  logic                  i_areset_n,
  input  logic [AWIDTH-1:0]     i_aw_addr,
  input  logic                  i_aw_valid,
  output logic                  o_aw_ready,
  input  logic [DWIDTH-1:0]     i_w_data,
  input  logic [DWIDTH/8-1:0]   i_w_strb,
  input  logic                  i_w_valid,
  output logic                  o_w_ready,
  input  logic [AWIDTH-1:0]     i_ar_addr,
  input  logic                  i_ar_valid,
  output logic                  o_ar_ready,
  output logic [1:0]            o_b_resp,
  output logic                  o_b_valid,
  input  logic                  i_b_ready,
  output logic [DWIDTH-1:0]     o_r_data,
  output logic [1:0]            o_r_resp,
  output logic                  o_r_valid,
  input  logic                  i_r_ready,
  output logic [AWIDTH-1:0]     o_reg_addr,
  output logic                  o_reg_wr_en,
  output logic [DWIDTH-1:0]     o_reg_wdata,
  output logic [DWIDTH/8-1:0]   o_reg_wstrb,
  output logic                  o_reg_rd_en,
  input  logic [DWIDTH-1:0]     i_reg_rdata,
  input  logic                  i_reg_err
);

  localparam int c_STRB_W = DWIDTH / 8;

  state_e                state_q,  state_d;
  logic [AWIDTH-1:0]     addr_q,   addr_d;
  logic [DWIDTH-1:0]     wdata_q,  wdata_d;
  logic [c_STRB_W-1:0]   wstrb_q,  wstrb_d;
  logic [1:0]            b_resp_q, b_resp_d;
  logic [DWIDTH-1:0]     r_data_q, r_data_d;
  logic [1:0]            r_resp_q, r_resp_d;

  logic w_wr_req;
  logic w_rd_req;
  logic w_grant_valid;
  logic w_grant;

  // A write is only a request once both address and data are present.
  assign w_wr_req = i_aw_valid & i_w_valid;
  assign w_rd_req = i_ar_valid;

`ifdef AXIL_ACCESS_SCHED_RR_EN
  logic w_accept;
  assign w_accept = o_aw_ready | o_ar_ready;
`endif

  axil_access_grant u_grant (
`ifdef AXIL_ACCESS_SCHED_RR_EN
    .i_clock    (i_clock),
    .i_areset_n (i_areset_n),
    .i_accept   (w_accept),
`endif
    .i_wr_req   (w_wr_req),
    .i_rd_req   (w_rd_req),
    .o_valid    (w_grant_valid),
    .o_grant    (w_grant)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    b_resp_d    = b_resp_q;
    r_data_d    = r_data_q;
    r_resp_d    = r_resp_q;
    o_aw_ready  = 1'b0;
    o_w_ready   = 1'b0;
    o_ar_ready  = 1'b0;
    o_reg_wr_en = 1'b0;
    o_reg_rd_en = 1'b0;
    o_b_valid   = 1'b0;
    o_r_valid   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Readies are combinational, so hold them low while reset is applied.
        if (w_grant_valid && i_areset_n) begin
          if (w_grant == GRANT_WRITE) begin
            o_aw_ready = 1'b1;
            o_w_ready  = 1'b1;
            addr_d     = i_aw_addr;
            wdata_d    = i_w_data;
            wstrb_d    = i_w_strb;
            state_d    = S_WR_ACCESS;
          end else begin
            o_ar_ready = 1'b1;
            addr_d     = i_ar_addr;
            state_d    = S_RD_ACCESS;
          end
        end
      end
      S_WR_ACCESS: begin
        o_reg_wr_en = 1'b1;
        b_resp_d    = resp_of(i_reg_err);
        state_d     = S_B_RESP;
      end
      S_B_RESP: begin
        o_b_valid = 1'b1;
        if (i_b_ready) begin
          state_d = S_IDLE;
        end
      end
      S_RD_ACCESS: begin
        o_reg_rd_en = 1'b1;
        r_data_d    = i_reg_rdata;
        r_resp_d    = resp_of(i_reg_err);
        state_d     = S_R_RESP;
      end
      S_R_RESP: begin
        o_r_valid = 1'b1;
        if (i_r_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      b_resp_q <= RESP_OKAY;
      r_data_q <= '0;
      r_resp_q <= RESP_OKAY;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      b_resp_q <= b_resp_d;
      r_data_q <= r_data_d;
      r_resp_q <= r_resp_d;
    end
  end

  assign o_reg_addr  = addr_q;
  assign o_reg_wdata = wdata_q;
  assign o_reg_wstrb = wstrb_q;
  assign o_b_resp    = b_resp_q;
  assign o_r_data    = r_data_q;
  assign o_r_resp    = r_resp_q;

endmodule
`default_nettype wire

// File: tb/tb_axil_access_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_access_scheduler
// Description : Self-checking bench for axil_access_scheduler: directed cases
//               plus randomized traffic against a transaction-level model.
//               Honours AXIL_ACCESS_SCHED_RR_EN for the expected grant policy.
// Revision    : 1.0
// ============================================================================
module tb_axil_access_scheduler;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] aw_addr = '0;
  logic          aw_valid = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic [SW-1:0] w_strb = '0;
  logic          w_valid = 1'b0;
  logic [AW-1:0] ar_addr = '0;
  logic          ar_valid = 1'b0;
  logic          b_ready = 1'b0;
  logic          r_ready = 1'b0;
  logic [DW-1:0] reg_rdata = '0;
  logic          reg_err = 1'b0;

  logic          o_aw_ready, o_w_ready, o_ar_ready;
  logic [1:0]    o_b_resp, o_r_resp;
  logic          o_b_valid, o_r_valid;
  logic [DW-1:0] o_r_data, o_reg_wdata;
  logic [AW-1:0] o_reg_addr;
  logic          o_reg_wr_en, o_reg_rd_en;
  logic [SW-1:0] o_reg_wstrb;

  always #5 clk = ~clk;

  axil_access_scheduler #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .i_clock     (clk),
    .i_areset_n  (rst_n),
    .i_aw_addr   (aw_addr),
    .i_aw_valid  (aw_valid),
    .o_aw_ready  (o_aw_ready),
    .i_w_data    (w_data),
    .i_w_strb    (w_strb),
    .i_w_valid   (w_valid),
    .o_w_ready   (o_w_ready),
    .i_ar_addr   (ar_addr),
    .i_ar_valid  (ar_valid),
    .o_ar_ready  (o_ar_ready),
    .o_b_resp    (o_b_resp),
    .o_b_valid   (o_b_valid),
    .i_b_ready   (b_ready),
    .o_r_data    (o_r_data),
    .o_r_resp    (o_r_resp),
    .o_r_valid   (o_r_valid),
    .i_r_ready   (r_ready),
    .o_reg_addr  (o_reg_addr),
    .o_reg_wr_en (o_reg_wr_en),
    .o_reg_wdata (o_reg_wdata),
    .o_reg_wstrb (o_reg_wstrb),
    .o_reg_rd_en (o_reg_rd_en),
    .i_reg_rdata (reg_rdata),
    .i_reg_err   (reg_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {o_aw_ready, o_w_ready, o_ar_ready, o_b_resp, o_b_valid, o_r_data,
            o_r_resp, o_r_valid, o_reg_addr, o_reg_wr_en, o_reg_wdata,
            o_reg_wstrb, o_reg_rd_en};
  endfunction

  // Upstream request queues; the driver holds each head valid until handshake.
  typedef struct packed { logic [DW-1:0] d; logic [SW-1:0] s; } wbeat_t;
  logic [AW-1:0] aw_q[$];
  wbeat_t        w_q[$];
  logic [AW-1:0] ar_q[$];
  int            rdy_mode  = 0;   // 0: always ready, 1: random, 2: stalled
  bit            rand_reg  = 1'b0;
  logic [DW-1:0] fix_rdata = '0;
  logic          fix_err   = 1'b0;
  bit            hs_aw, hs_w, hs_ar;

  // Transaction-level model: one outstanding request and its age in cycles.
  bit            m_busy = 1'b0;
  bit            m_is_wr = 1'b0;
  bit            m_last_wr = 1'b0;
  int            m_age = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [SW-1:0] m_wstrb = '0;
  logic [DW-1:0] m_rdata = '0;
  logic [1:0]    m_resp = '0;

  bit            log_en = 1'b0;
  logic [7:0]    grant_log = '0;
  int            grant_n = 0;
  int            wr_en_cnt = 0;

  // Driver: applies queue heads and response readies just after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (hs_aw && aw_q.size() != 0) void'(aw_q.pop_front());
      if (hs_w  && w_q.size()  != 0) void'(w_q.pop_front());
      if (hs_ar && ar_q.size() != 0) void'(ar_q.pop_front());
      aw_valid = (aw_q.size() != 0);
      if (aw_valid) aw_addr = aw_q[0];
      w_valid = (w_q.size() != 0);
      if (w_valid) begin
        w_data = w_q[0].d;
        w_strb = w_q[0].s;
      end
      ar_valid = (ar_q.size() != 0);
      if (ar_valid) ar_addr = ar_q[0];
      case (rdy_mode)
        0:       begin b_ready = 1'b1; r_ready = 1'b1; end
        1:       begin b_ready = 1'($urandom_range(0, 1)); r_ready = 1'($urandom_range(0, 1)); end
        default: begin b_ready = 1'b0; r_ready = 1'b0; end
      endcase
      if (rand_reg) begin
        reg_rdata = $urandom;
        reg_err   = ($urandom_range(0, 3) == 0);
      end else begin
        reg_rdata = fix_rdata;
        reg_err   = fix_err;
      end
    end
  end

  // Compare process: predict outputs from the model, check, then advance it.
  initial begin
    forever begin
      bit wr_req, rd_req, g_wr, g_rd;
      bit e_wr_en, e_rd_en, e_bv, e_rv;
      @(negedge clk);
      hs_aw = aw_valid && o_aw_ready;
      hs_w  = w_valid  && o_w_ready;
      hs_ar = ar_valid && o_ar_ready;
      if (o_reg_wr_en) wr_en_cnt++;
      if (log_en && hs_aw) begin grant_log = {grant_log[6:0], 1'b1}; grant_n++; end
      if (log_en && hs_ar) begin grant_log = {grant_log[6:0], 1'b0}; grant_n++; end
      if (!rst_n) begin
        chk("reset_outputs", all_outs(), '0);
        m_busy    = 1'b0;
        m_last_wr = 1'b0;
        hs_aw = 1'b0; hs_w = 1'b0; hs_ar = 1'b0;
      end else begin
        wr_req = aw_valid && w_valid;
        rd_req = ar_valid;
`ifdef AXIL_ACCESS_SCHED_RR_EN
        g_wr = wr_req && (!rd_req || !m_last_wr);
`else
        g_wr = wr_req;
`endif
        g_rd    = rd_req && !g_wr;
        e_wr_en = m_busy && m_is_wr  && (m_age == 1);
        e_rd_en = m_busy && !m_is_wr && (m_age == 1);
        e_bv    = m_busy && m_is_wr  && (m_age >= 2);
        e_rv    = m_busy && !m_is_wr && (m_age >= 2);
        chk("aw_ready", o_aw_ready, !m_busy && g_wr);
        chk("w_ready",  o_w_ready,  !m_busy && g_wr);
        chk("ar_ready", o_ar_ready, !m_busy && g_rd);
        chk("reg_wr_en", o_reg_wr_en, e_wr_en);
        chk("reg_rd_en", o_reg_rd_en, e_rd_en);
        chk("b_valid", o_b_valid, e_bv);
        chk("r_valid", o_r_valid, e_rv);
        if (e_wr_en) begin
          chk("wr_addr",  o_reg_addr,  m_addr);
          chk("wr_wdata", o_reg_wdata, m_wdata);
          chk("wr_wstrb", o_reg_wstrb, m_wstrb);
          m_resp = reg_err ? 2'b10 : 2'b00;
        end
        if (e_rd_en) begin
          chk("rd_addr", o_reg_addr, m_addr);
          m_rdata = reg_rdata;
          m_resp  = reg_err ? 2'b10 : 2'b00;
        end
        if (e_bv) chk("b_resp", o_b_resp, m_resp);
        if (e_rv) begin
          chk("r_data", o_r_data, m_rdata);
          chk("r_resp", o_r_resp, m_resp);
        end
        if (!m_busy) begin
          if (g_wr) begin
            m_busy = 1'b1; m_is_wr = 1'b1; m_age = 1; m_last_wr = 1'b1;
            m_addr = aw_addr; m_wdata = w_data; m_wstrb = w_strb;
          end else if (g_rd) begin
            m_busy = 1'b1; m_is_wr = 1'b0; m_age = 1; m_last_wr = 1'b0;
            m_addr = ar_addr;
          end
        end else if ((e_bv && b_ready) || (e_rv && r_ready)) begin
          m_busy = 1'b0;
        end else begin
          m_age++;
        end
      end
    end
  end

  task automatic drain(input int bound);
    int k = 0;
    while ((aw_q.size() != 0 || w_q.size() != 0 || ar_q.size() != 0 || m_busy) && k < bound) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("drain_timeout", (k >= bound), 1'b0);
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    wbeat_t wb;
    wb.d = d;
    wb.s = s;
    aw_q.push_back(a);
    w_q.push_back(wb);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int wr_base;
    int w_owed;
    wbeat_t wb;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_aw_ready", o_aw_ready, 1'b0);
    chk("rst_b_valid", o_b_valid, 1'b0);
    chk("rst_r_data", o_r_data, 32'h0);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single write with literal timing
    #1;
    rand_reg = 1'b0; fix_err = 1'b0; rdy_mode = 0;
    push_wr(8'h10, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    chk("lit_wr_aw_ready", o_aw_ready, 1'b1);
    chk("lit_wr_w_ready", o_w_ready, 1'b1);
    @(negedge clk);
    chk("lit_wr_en", o_reg_wr_en, 1'b1);
    chk("lit_wr_addr", o_reg_addr, 8'h10);
    chk("lit_wr_data", o_reg_wdata, 32'hDEADBEEF);
    chk("lit_wr_strb", o_reg_wstrb, 4'hF);
    @(negedge clk);
    chk("lit_b_valid", o_b_valid, 1'b1);
    chk("lit_b_resp", o_b_resp, 2'b00);

    // Read with error, response stalled; issued so it lands in N+3
    #1;
    fix_err = 1'b1; fix_rdata = 32'h12345678; rdy_mode = 2;
    ar_q.push_back(8'hFC);
    @(negedge clk);
    chk("lit_idle_after_wr", o_ar_ready, 1'b1);
    @(negedge clk);
    chk("lit_rd_en", o_reg_rd_en, 1'b1);
    chk("lit_rd_addr", o_reg_addr, 8'hFC);
    #1;
    fix_rdata = 32'hA5A5A5A5;
    ar_q.push_back(8'h20);
    repeat (4) begin
      @(negedge clk);
      chk("lit_r_valid_hold", o_r_valid, 1'b1);
      chk("lit_r_data_hold", o_r_data, 32'h12345678);
      chk("lit_r_resp_hold", o_r_resp, 2'b10);
      chk("lit_ar_blocked", o_ar_ready, 1'b0);
    end
    #1 rdy_mode = 0;
    drain(100);

    // Lone AW for 5 cycles, then W
    fix_err = 1'b0;
    wr_base = wr_en_cnt;
    aw_q.push_back(8'h24);
    repeat (5) begin
      @(negedge clk);
      chk("lone_aw_ready", o_aw_ready, 1'b0);
      chk("lone_w_ready", o_w_ready, 1'b0);
    end
    #1;
    wb.d = 32'h0BADF00D; wb.s = 4'h3;
    w_q.push_back(wb);
    @(negedge clk);
    chk("pair_aw_ready", o_aw_ready, 1'b1);
    chk("pair_w_ready", o_w_ready, 1'b1);
    #1 drain(100);
    chk("single_wr_en", wr_en_cnt - wr_base, 1);

    // Reset while in B_RESP
    rdy_mode = 2;
    push_wr(8'h30, 32'hCAFEF00D, 4'hF);
    k = 0;
    do begin @(negedge clk); k++; end while (!o_b_valid && k < 20);
    chk("reach_b_resp", o_b_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("rst_in_b_resp", all_outs(), '0);
    @(negedge clk);
    #2;
    rst_n = 1'b1; rdy_mode = 0;
    push_wr(8'h44, 32'h11112222, 4'hC);
    @(negedge clk);
    chk("post_rst_aw_ready", o_aw_ready, 1'b1);
    chk("post_rst_no_b_valid", o_b_valid, 1'b0);
    #1 drain(100);

    // Reset while in RD_ACCESS
    ar_q.push_back(8'h50);
    k = 0;
    do begin @(negedge clk); k++; end while (!o_reg_rd_en && k < 20);
    chk("reach_rd_access", o_reg_rd_en, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("rst_in_rd_access", all_outs(), '0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    ar_q.push_back(8'h54);
    @(negedge clk);
    chk("post_rst_ar_ready", o_ar_ready, 1'b1);
    chk("post_rst_no_r_valid", o_r_valid, 1'b0);
    #1 drain(100);

    // Four simultaneous reads and writes
    grant_log = '0; grant_n = 0; log_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_wr(AW'($urandom), $urandom, SW'($urandom));
      ar_q.push_back(AW'($urandom));
    end
    drain(200);
    log_en = 1'b0;
    chk("conflict_grant_count", grant_n, 8);
`ifdef AXIL_ACCESS_SCHED_RR_EN
    chk("conflict_order_rr", grant_log, 8'b1010_1010);
`else
    chk("conflict_order_fixed", grant_log, 8'b1111_0000);
`endif

    // Randomized traffic
    rand_reg = 1'b1; rdy_mode = 1; w_owed = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      #1;
      if (aw_q.size() < 3 && $urandom_range(0, 3) == 0) begin
        aw_q.push_back(AW'($urandom));
        if ($urandom_range(0, 1) == 1) begin
          wb.d = $urandom; wb.s = SW'($urandom);
          w_q.push_back(wb);
        end else begin
          w_owed++;
        end
      end
      if (w_owed > 0 && $urandom_range(0, 2) == 0) begin
        wb.d = $urandom; wb.s = SW'($urandom);
        w_q.push_back(wb);
        w_owed--;
      end
      if (ar_q.size() < 3 && $urandom_range(0, 3) == 0) ar_q.push_back(AW'($urandom));
    end
    while (w_owed > 0) begin
      wb.d = $urandom; wb.s = SW'($urandom);
      w_q.push_back(wb);
      w_owed--;
    end
    rdy_mode = 0;
    drain(1000);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
